// File: rtl/mvm_pkg.sv
// mvm_pkg: operand/result widths and FSM state encoding shared by the MVM feeder and its operand memory
package mvm_pkg;
  localparam int OP_W  = 8;
  localparam int RES_W = 16;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_ISSUE, ST_DRAIN, ST_OUT} state_t;
endpackage

// File: rtl/mvm_opmem.sv
// mvm_opmem: register-array storage for weight matrix W (M*N) and input vector x (N), combinational read
// Ports: i_we/i_sel/i_addr/i_data write port (i_sel 0 = W, 1 = x); i_w_idx/i_x_idx read
// addresses; o_w/o_x read data. Contents are not reset.
module mvm_opmem import mvm_pkg::*; #(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int AW = $clog2(M*N),
  parameter int XW = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic                   i_sel,
  input  logic [AW-1:0]          i_addr,
  input  logic signed [OP_W-1:0] i_data,
  input  logic [AW-1:0]          i_w_idx,
  input  logic [XW-1:0]          i_x_idx,
  output logic signed [OP_W-1:0] o_w,
  output logic signed [OP_W-1:0] o_x
);
  logic signed [OP_W-1:0] r_w [M*N];
  logic signed [OP_W-1:0] r_x [N];
  always_ff @(posedge clk) begin
    if (i_we && !i_sel && int'(i_addr) < M*N) r_w[i_addr] <= i_data;
    if (i_we && i_sel && int'(i_addr) < N) r_x[i_addr[XW-1:0]] <= i_data;
  end
  assign o_w = r_w[i_w_idx];
  assign o_x = r_x[i_x_idx];
endmodule

// File: rtl/mvm_feeder.sv
// mvm_feeder: sequences y = W*x through an external MAC, one row at a time, with a valid/ready result stream
// Ports: wr_* operand write port (IDLE only); start/busy/done run control; mac_* MAC operand
// and result interface; y_data/y_idx/y_valid/y_ready row result stream.
module mvm_feeder import mvm_pkg::*; #(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_en,
  input  logic                      wr_sel,
  input  logic [$clog2(M*N)-1:0]    wr_addr,
  input  logic signed [OP_W-1:0]    wr_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic signed [OP_W-1:0]    mac_a,
  output logic signed [OP_W-1:0]    mac_b,
  output logic                      mac_valid_in,
  output logic                      mac_clear,
  input  logic signed [RES_W-1:0]   mac_f,
  input  logic                      mac_valid_out,
  output logic signed [RES_W-1:0]   y_data,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [$clog2(M)-1:0]      y_idx
);
  localparam int AW = $clog2(M*N);
  localparam int XW = $clog2(N);
  localparam int RW = $clog2(M);
  localparam int VW = $clog2(N+1);
  state_t                  r_state;
  logic [RW-1:0]           r_row;
  logic [XW-1:0]           r_col;
  logic [VW-1:0]           r_vcnt;
  logic signed [RES_W-1:0] r_y;
  logic                    r_done;
  logic                    w_we;
  logic [AW-1:0]           w_w_idx;
  logic signed [OP_W-1:0]  w_w;
  logic signed [OP_W-1:0]  w_x;
  // A write coinciding with an accepted start is dropped so the run sees the old operands.
  assign w_we    = wr_en && r_state == ST_IDLE && !start;
  assign w_w_idx = AW'(int'(r_row) * N + int'(r_col));
  mvm_opmem #(.M(M), .N(N), .AW(AW), .XW(XW)) u_opmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_sel   (wr_sel),
    .i_addr  (wr_addr),
    .i_data  (wr_data),
    .i_w_idx (w_w_idx),
    .i_x_idx (r_col),
    .o_w     (w_w),
    .o_x     (w_x)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_vcnt  <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_state <= ST_CLEAR;
          r_row   <= '0;
        end
        ST_CLEAR: begin
          r_state <= ST_ISSUE;
          r_col   <= '0;
          r_vcnt  <= '0;
        end
        // Results may already return while later operands are still issuing, so count here too.
        ST_ISSUE: begin
          if (mac_valid_out) r_vcnt <= r_vcnt + 1'b1;
          if (r_col == XW'(N-1)) r_state <= ST_DRAIN;
          else r_col <= r_col + 1'b1;
        end
        // The count reaching N one cycle after the last pulse gives the accumulator time to settle.
        ST_DRAIN: if (r_vcnt == VW'(N)) begin
          r_y     <= mac_f;
          r_state <= ST_OUT;
        end else if (mac_valid_out) r_vcnt <= r_vcnt + 1'b1;
        ST_OUT: if (y_ready) begin
          if (r_row == RW'(M-1)) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state <= ST_CLEAR;
            r_row   <= r_row + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign busy         = r_state != ST_IDLE;
  assign done         = r_done;
  assign mac_valid_in = r_state == ST_ISSUE;
  // Held high during reset so an interrupted accumulation is discarded.
  assign mac_clear    = !reset_n || r_state == ST_CLEAR;
  assign mac_a        = mac_valid_in ? w_w : '0;
  assign mac_b        = mac_valid_in ? w_x : '0;
  assign y_valid      = r_state == ST_OUT;
  assign y_data       = r_y;
  assign y_idx        = r_row;
endmodule

// File: tb/tb_mvm_feeder.sv
// tb_mvm_feeder: scoreboard bench for mvm_feeder with a 2-cycle MAC model attached
module tb_mvm_feeder;
  localparam int M = 4;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en = 1'b0;
  logic wr_sel = 1'b0;
  logic [3:0] wr_addr = '0;
  logic signed [7:0] wr_data = '0;
  logic start = 1'b0;
  logic y_ready = 1'b1;
  logic busy, done, mac_valid_in, mac_clear, y_valid, mac_valid_out;
  logic signed [7:0] mac_a, mac_b;
  logic signed [15:0] mac_f, y_data;
  logic [1:0] y_idx;
  always #5 clk = ~clk;
  mvm_feeder #(.M(M), .N(N)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid_in(mac_valid_in), .mac_clear(mac_clear), .mac_f(mac_f), .mac_valid_out(mac_valid_out),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready), .y_idx(y_idx)
  );
  logic signed [15:0] p1;
  logic v1;
  always_ff @(posedge clk) begin
    if (mac_clear) begin
      p1 <= '0;
      v1 <= 1'b0;
      mac_f <= '0;
      mac_valid_out <= 1'b0;
    end else begin
      p1 <= {{8{mac_a[7]}}, mac_a} * {{8{mac_b[7]}}, mac_b};
      v1 <= mac_valid_in;
      mac_valid_out <= v1;
      if (v1) mac_f <= mac_f + p1;
    end
  end
  int n_checks = 0;
  int n_errs = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  logic signed [7:0] wm [M*N];
  logic signed [7:0] xm [N];
  int q_y[$], q_idx[$], q_a[$], q_b[$];
  int exp_done = 0;
  int rdy_mode = 0;
  int stall_left = 0;
  task automatic push_run();
    int acc;
    logic signed [15:0] t;
    for (int r = 0; r < M; r++) begin
      acc = 0;
      for (int c = 0; c < N; c++) begin
        acc += int'(wm[r*N+c]) * int'(xm[c]);
        q_a.push_back(int'(wm[r*N+c]));
        q_b.push_back(int'(xm[c]));
      end
      t = acc[15:0];
      q_y.push_back(int'(t));
      q_idx.push_back(r);
    end
    exp_done++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic sel, input int addr, input logic signed [7:0] d);
    wr_en = 1'b1;
    wr_sel = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (sel) xm[addr] = d;
    else wm[addr] = d;
  endtask
  task automatic load(input int kind);
    for (int i = 0; i < M*N; i++)
      wr(1'b0, i, kind == 0 ? 8'((i / N) == (i % N)) : kind == 1 ? 8'sd127 : 8'($urandom_range(0, 255)));
    for (int i = 0; i < N; i++)
      wr(1'b1, i, kind == 0 ? 8'(i + 1) : kind == 1 ? -8'sd128 : 8'($urandom_range(0, 255)));
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      tick();
      k++;
    end
    chk("done_seen", int'(done), 1);
    tick();
  endtask
  task automatic run_std();
    push_run();
    pulse_start();
    wait_done();
  endtask
  // Stimulus disturbance: a write during ISSUE and a start during DRAIN must both be ignored.
  task automatic run_disturbed();
    int k = 0;
    push_run();
    pulse_start();
    while (!mac_valid_in && k < 100) begin tick(); k++; end
    chk("reach_issue", int'(mac_valid_in), 1);
    wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 4'd0; wr_data = ~xm[0];
    tick();
    wr_en = 1'b0;
    k = 0;
    while (!(busy && !mac_valid_in && !mac_clear && !y_valid) && k < 100) begin tick(); k++; end
    chk("reach_drain", int'(busy && !y_valid), 1);
    pulse_start();
    wait_done();
  endtask
  // y_ready driver: always ready, random, or five stalled cycles on row 1.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 1) y_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2 && y_valid && y_idx == 2'd1 && stall_left > 0) begin
      y_ready = 1'b0;
      stall_left--;
    end else y_ready = 1'b1;
  end
  logic hold = 1'b0, p_vin = 1'b0, p_clr = 1'b0, p_rst = 1'b0;
  int h_data, h_idx;
  always @(negedge clk) begin
    if (reset_n) begin
      if (hold) begin
        chk("y_hold_valid", int'(y_valid), 1);
        chk("y_hold_data", int'(y_data), h_data);
        chk("y_hold_idx", int'(y_idx), h_idx);
      end
      if (y_valid && y_ready) begin
        chk("y_expected", int'(q_y.size() != 0), 1);
        if (q_y.size() != 0) begin
          chk("y_data", int'(y_data), q_y.pop_front());
          chk("y_idx", int'(y_idx), q_idx.pop_front());
        end
      end
      if (mac_valid_in) begin
        chk("op_expected", int'(q_a.size() != 0), 1);
        chk("issue_during_out", int'(y_valid), 0);
        if (q_a.size() != 0) begin
          chk("mac_a", int'(mac_a), q_a.pop_front());
          chk("mac_b", int'(mac_b), q_b.pop_front());
        end
        if (!p_vin) chk("clear_before_issue", int'(p_clr), 1);
      end
      if (mac_clear && p_rst) chk("clear_len", int'(p_clr), 0);
      if (done) begin
        chk("done_busy", int'(busy), 0);
        chk("done_expected", int'(exp_done > 0), 1);
        chk("done_y_drained", q_y.size(), 0);
        if (exp_done > 0) exp_done--;
      end
      hold = y_valid && !y_ready;
      h_data = int'(y_data);
      h_idx = int'(y_idx);
    end else hold = 1'b0;
    p_vin = mac_valid_in;
    p_clr = mac_clear;
    p_rst = reset_n;
  end
  task automatic chk_reset_outputs();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_y_data", int'(y_data), 0);
    chk("rst_y_idx", int'(y_idx), 0);
    chk("rst_mac_valid_in", int'(mac_valid_in), 0);
    chk("rst_mac_a", int'(mac_a), 0);
    chk("rst_mac_b", int'(mac_b), 0);
    chk("rst_mac_clear", int'(mac_clear), 1);
  endtask
  initial begin
    int k;
    #1;
    chk_reset_outputs();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    load(0);
    run_std();
    load(1);
    run_std();
    load(2);
    rdy_mode = 2;
    stall_left = 5;
    run_std();
    rdy_mode = 0;
    load(2);
    run_disturbed();
    run_std();
    load(2);
    push_run();
    pulse_start();
    k = 0;
    while (!(mac_valid_in && y_idx == 2'd2) && k < 500) begin tick(); k++; end
    chk("reach_row2_issue", int'(mac_valid_in && y_idx == 2'd2), 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs();
    q_y.delete(); q_idx.delete(); q_a.delete(); q_b.delete();
    exp_done = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    run_std();
    push_run();
    start = 1'b1;
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = wm[5] + 8'sd1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done();
    rdy_mode = 1;
    repeat (3) begin
      load(2);
      run_std();
    end
    rdy_mode = 0;
    repeat (4) tick();
    chk("final_y_queue", q_y.size(), 0);
    chk("final_op_queue", q_a.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errs);
    $fatal(1);
  end
endmodule
